// File: rtl/pipe_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_alu_pkg
// Description : Instruction layout, func codes and register-file constants
//               shared by the pipeline_ALU issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_alu_pkg;

    localparam int INSTR_W   = 24;
    localparam int FIELD_W   = 4;
    localparam int ADDR_W    = 8;
    localparam int FUNC_LSB  = 20;
    localparam int RS1_LSB   = 16;
    localparam int RS2_LSB   = 12;
    localparam int RD_LSB    = 8;
    localparam int ADDR_LSB  = 0;

    localparam int REG_COUNT = 16;
    localparam int NUM_FUNC  = 12;

    localparam logic [FIELD_W-1:0] FN_ADD = 4'd0;
    localparam logic [FIELD_W-1:0] FN_SUB = 4'd1;
    localparam logic [FIELD_W-1:0] FN_MUL = 4'd2;
    localparam logic [FIELD_W-1:0] FN_SLA = 4'd11;

    // Field order matches the packed word: func is the top nibble.
    typedef struct packed {
        logic [FIELD_W-1:0] func;
        logic [FIELD_W-1:0] rs1;
        logic [FIELD_W-1:0] rs2;
        logic [FIELD_W-1:0] rd;
        logic [ADDR_W-1:0]  addr;
    } instr_t;

    function automatic logic func_legal(input logic [FIELD_W-1:0] f, input int num_func);
        return int'(f) < num_func;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_alu_issue_if
// Description : Instruction intake handshake plus the issue bus to pipeline_ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_alu_issue_if;

    logic                                in_valid;
    logic                                in_ready;
    logic [pipe_alu_pkg::INSTR_W-1:0]    in_instr;
    logic                                iss_valid;
    logic [pipe_alu_pkg::FIELD_W-1:0]    rs1;
    logic [pipe_alu_pkg::FIELD_W-1:0]    rs2;
    logic [pipe_alu_pkg::FIELD_W-1:0]    rd;
    logic [pipe_alu_pkg::FIELD_W-1:0]    func;
    logic [pipe_alu_pkg::ADDR_W-1:0]     addr;

    modport master (
        output in_valid, in_instr,
        input  in_ready, iss_valid, rs1, rs2, rd, func, addr
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready, iss_valid, rs1, rs2, rd, func, addr
    );

endinterface
`default_nettype wire

// File: rtl/pipe_alu_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_alu_fifo
// Description : Synchronous in-order FIFO with occupancy output; no bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_alu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_wdata,
    output logic      [WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wptr;
    logic [c_AW:0]    r_rptr;
    logic             w_wr;
    logic             w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign o_level = r_wptr - r_rptr;
    assign o_rdata = r_mem[r_rptr[c_AW-1:0]];

    assign w_rd = i_pop && !o_empty;
    assign w_wr = i_push && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (c_AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : pipe_alu_issue
// Description : In-order issue stage for pipeline_ALU with RAW interlock,
//               illegal-func drop and hazard-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_alu_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int WB_LAT     = 3,
    parameter int NUM_FUNC   = pipe_alu_pkg::NUM_FUNC
) (
    input  wire logic                         clk1,
    input  wire logic                         rst,
    pipe_alu_issue_if.slave                   bus,
    output logic                              illegal,
    output logic [15:0]                       stall_cnt,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
    import pipe_alu_pkg::*;

    localparam int                    c_PEND_W    = $clog2(WB_LAT) + 1;
    localparam logic [c_PEND_W-1:0]   c_PEND_LOAD = c_PEND_W'(WB_LAT - 1);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [INSTR_W-1:0]    w_head_raw;
    instr_t                w_head;
    logic                  w_head_illegal;
    logic                  w_hazard;
    logic                  w_issue;

    logic [c_PEND_W-1:0]   r_pending [REG_COUNT];
    logic                  r_iss_valid;
    logic                  r_illegal;
    logic [FIELD_W-1:0]    r_rs1;
    logic [FIELD_W-1:0]    r_rs2;
    logic [FIELD_W-1:0]    r_rd;
    logic [FIELD_W-1:0]    r_func;
    logic [ADDR_W-1:0]     r_addr;
    logic [15:0]           r_stall_cnt;

    assign bus.in_ready = !w_full && !rst;
    assign w_push       = bus.in_valid && bus.in_ready;

    pipe_alu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk1),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (bus.in_instr),
        .o_rdata (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // Head decision: illegal drop, RAW stall, or issue -- mutually exclusive.
    assign w_head         = instr_t'(w_head_raw);
    assign w_head_illegal = !w_empty && !func_legal(w_head.func, NUM_FUNC);
    assign w_hazard       = !w_empty && !w_head_illegal &&
                            ((r_pending[w_head.rs1] != '0) || (r_pending[w_head.rs2] != '0));
    assign w_issue        = !w_empty && !w_head_illegal && !w_hazard;
    assign w_pop          = w_head_illegal || w_issue;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_func      <= '0;
            r_addr      <= '0;
            r_stall_cnt <= '0;
            for (int i = 0; i < REG_COUNT; i++) r_pending[i] <= '0;
        end else begin
            r_iss_valid <= w_issue;
            r_illegal   <= w_head_illegal;
            if (w_issue) begin
                r_rs1  <= w_head.rs1;
                r_rs2  <= w_head.rs2;
                r_rd   <= w_head.rd;
                r_func <= w_head.func;
                r_addr <= w_head.addr;
            end
            if (w_hazard && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
            for (int i = 0; i < REG_COUNT; i++) begin
                if (r_pending[i] != '0) r_pending[i] <= r_pending[i] - c_PEND_W'(1);
            end
            // Later assignment lets a fresh load override the decrement.
            if (w_issue) r_pending[w_head.rd] <= c_PEND_LOAD;
        end
    end

    assign bus.iss_valid = r_iss_valid;
    assign bus.rs1       = r_rs1;
    assign bus.rs2       = r_rs2;
    assign bus.rd        = r_rd;
    assign bus.func      = r_func;
    assign bus.addr      = r_addr;
    assign illegal       = r_illegal;
    assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_alu_issue
// Description : Scoreboard bench for pipe_alu_issue (FIFO_DEPTH=4, WB_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_alu_issue;

    localparam int c_WB_LAT = 3;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        illegal;
    logic [15:0] stall_cnt;
    logic [2:0]  fifo_level;

    pipe_alu_issue_if bus ();

    pipe_alu_issue #(
        .FIFO_DEPTH (4),
        .WB_LAT     (c_WB_LAT),
        .NUM_FUNC   (12)
    ) dut (
        .clk1       (clk1),
        .rst        (rst),
        .bus        (bus),
        .illegal    (illegal),
        .stall_cnt  (stall_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk1 = ~clk1;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          acc_cyc;
    int          ill_cnt = 0;
    bit          saw_full;
    int          max_lvl;
    logic [23:0] sb [$];
    int          iss_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] d,
                                       input logic [7:0] ad);
        return {f, a, b, d, ad};
    endfunction

    always @(posedge clk1) cyc <= cyc + 1;

    // Output monitor: every issue must match the oldest outstanding legal word.
    always @(negedge clk1) begin
        if (bus.iss_valid === 1'b1) begin
            iss_cyc.push_back(cyc);
            if (sb.size() == 0)
                chk("unexpected_issue", {8'h00, bus.func, bus.rs1, bus.rs2, bus.rd, bus.addr}, 32'hFFFF_FFFF);
            else
                chk("issue_fields", {8'h00, bus.func, bus.rs1, bus.rs2, bus.rd, bus.addr}, {8'h00, sb.pop_front()});
        end
        if (illegal === 1'b1) ill_cnt++;
        if (fifo_level == 3'd4 && bus.in_ready === 1'b0) saw_full = 1'b1;
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end

    task automatic send(input logic [23:0] w, input bit legal);
        bit acc = 1'b0;
        int n   = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        while (!acc && n < 200) begin
            @(negedge clk1);
            acc = (bus.in_ready === 1'b1);
            @(posedge clk1);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("accept", {31'd0, acc}, 32'd1);
        if (acc) begin
            acc_cyc = cyc;
            if (legal) sb.push_back(w);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || fifo_level != 3'd0) && n < 100) begin
            @(posedge clk1);
            #1;
            n++;
        end
        chk(tag, {31'd0, (sb.size() == 0 && fifo_level == 3'd0)}, 32'd1);
        repeat (c_WB_LAT + 1) @(posedge clk1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s0;
        int i0;

        // Reset with a word already presented.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h00);
        repeat (3) @(posedge clk1);
        #1;
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
        chk("rst_level",     {29'd0, fifo_level}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_illegal",   {31'd0, illegal}, 32'd0);
        chk("rst_fields",    {8'h00, bus.func, bus.rs1, bus.rs2, bus.rd, bus.addr}, 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk1);
        #1;

        // Independent back-to-back stream.
        iss_cyc.delete();
        s0 = int'(stall_cnt);
        send(mk(4'd0, 4'd3, 4'd5, 4'd10, 8'h11), 1'b1);
        send(mk(4'd2, 4'd3, 4'd8, 4'd12, 8'h22), 1'b1);
        send(mk(4'd1, 4'd7, 4'd3, 4'd13, 8'h33), 1'b1);
        drain("t2_drain");
        chk("t2_count", iss_cyc.size(), 3);
        if (iss_cyc.size() == 3) begin
            chk("t2_gap01", iss_cyc[1] - iss_cyc[0], 1);
            chk("t2_gap12", iss_cyc[2] - iss_cyc[1], 1);
        end
        chk("t2_stall", int'(stall_cnt) - s0, 0);

        // RAW dependency through r10.
        iss_cyc.delete();
        s0 = int'(stall_cnt);
        send(mk(4'd0, 4'd3, 4'd5, 4'd10, 8'h40), 1'b1);
        send(mk(4'd1, 4'd10, 4'd5, 4'd14, 8'h41), 1'b1);
        drain("t3_drain");
        chk("t3_count", iss_cyc.size(), 2);
        if (iss_cyc.size() == 2) chk("t3_raw_gap", iss_cyc[1] - iss_cyc[0], c_WB_LAT);
        chk("t3_stall", int'(stall_cnt) - s0, 2);

        // Illegal func sandwiched between two legal adds.
        iss_cyc.delete();
        i0 = ill_cnt;
        send(mk(4'd0, 4'd1, 4'd2, 4'd5, 8'h50), 1'b1);
        send(mk(4'd13, 4'd6, 4'd7, 4'd9, 8'h51), 1'b0);
        send(mk(4'd0, 4'd6, 4'd7, 4'd8, 8'h52), 1'b1);
        drain("t4_drain");
        chk("t4_illegal_pulses", ill_cnt - i0, 1);
        chk("t4_count", iss_cyc.size(), 2);

        // Dependency chain keeps the head stalled until the queue fills.
        iss_cyc.delete();
        saw_full = 1'b0;
        max_lvl  = 0;
        send(mk(4'd0, 4'd3, 4'd5, 4'd10, 8'h60), 1'b1);
        send(mk(4'd1, 4'd10, 4'd5, 4'd11, 8'h61), 1'b1);
        send(mk(4'd0, 4'd11, 4'd1, 4'd12, 8'h62), 1'b1);
        send(mk(4'd2, 4'd12, 4'd2, 4'd13, 8'h63), 1'b1);
        send(mk(4'd1, 4'd13, 4'd3, 4'd14, 8'h64), 1'b1);
        send(mk(4'd0, 4'd14, 4'd4, 4'd15, 8'h65), 1'b1);
        send(mk(4'd11, 4'd15, 4'd1, 4'd2, 8'h66), 1'b1);
        drain("t5_drain");
        chk("t5_full_seen", {31'd0, saw_full}, 32'd1);
        chk("t5_max_level", max_lvl, 4);
        chk("t5_count", iss_cyc.size(), 7);

        // Reset while the head is stalled with three words queued.
        send(mk(4'd0, 4'd4, 4'd5, 4'd9, 8'h70), 1'b1);
        send(mk(4'd0, 4'd9, 4'd1, 4'd10, 8'h71), 1'b1);
        send(mk(4'd1, 4'd10, 4'd5, 4'd11, 8'h72), 1'b1);
        send(mk(4'd0, 4'd11, 4'd2, 4'd12, 8'h73), 1'b1);
        send(mk(4'd2, 4'd12, 4'd3, 4'd13, 8'h74), 1'b1);
        chk("t6_level_before_rst", {29'd0, fifo_level}, 32'd3);
        @(negedge clk1);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_in_ready_in_rst", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk1);
        #1;
        chk("t6_level_after_rst", {29'd0, fifo_level}, 32'd0);
        chk("t6_iss_valid_after_rst", {31'd0, bus.iss_valid}, 32'd0);
        chk("t6_stall_after_rst", {16'd0, stall_cnt}, 32'd0);
        rst = 1'b0;
        iss_cyc.delete();
        send(mk(4'd0, 4'd10, 4'd5, 4'd7, 8'h80), 1'b1);
        drain("t6_drain");
        chk("t6_count", iss_cyc.size(), 1);
        if (iss_cyc.size() == 1) chk("t6_latency", iss_cyc[0] - acc_cyc, 1);
        chk("t6_stall", {16'd0, stall_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
